// File: rtl/taxi_axi_xbar_thread_ctrl_if.sv
// Admission/completion bundle between the crossbar datapath and the thread
// controller. The master side presents requests and completions. The slave
// side returns the admission decision and the outstanding count.
// Optional macro: TAXI_AXI_XBAR_THREAD_ERR_EN adds the sticky cpl_err flag.
interface taxi_axi_xbar_thread_ctrl_if #(
  parameter int ID_W  = 8,
  parameter int SEL_W = 2,
  parameter int CNT_W = 5
);
  logic [ID_W-1:0]  req_id;
  logic [SEL_W-1:0] req_sel;
  logic             req_valid;
  logic             req_ready;
  logic [ID_W-1:0]  cpl_id;
  logic             cpl_valid;
  logic [CNT_W-1:0] active_count;
  logic             busy;
`ifdef TAXI_AXI_XBAR_THREAD_ERR_EN
  logic             cpl_err;

  modport master (
    output req_id, req_sel, req_valid, cpl_id, cpl_valid,
    input  req_ready, active_count, busy, cpl_err
  );

  modport slave (
    input  req_id, req_sel, req_valid, cpl_id, cpl_valid,
    output req_ready, active_count, busy, cpl_err
  );
`else
  modport master (
    output req_id, req_sel, req_valid, cpl_id, cpl_valid,
    input  req_ready, active_count, busy
  );

  modport slave (
    input  req_id, req_sel, req_valid, cpl_id, cpl_valid,
    output req_ready, active_count, busy
  );
`endif
endinterface

// File: rtl/taxi_axi_xbar_thread_ctrl.sv
// Per-direction admission controller for one crossbar slave port.
// A thread table binds each in-flight ID to a single master port. A new
// address-phase request is admitted only if it cannot reorder same-ID
// responses that return from different master ports.
// Optional macro: TAXI_AXI_XBAR_THREAD_ERR_EN adds the sticky cpl_err flag
// for completions that match no tracked transaction.
module taxi_axi_xbar_thread_ctrl #(
  parameter int S_THREADS = 2,
  parameter int S_ACCEPT  = 16,
  parameter int ID_W      = 8,
  parameter int M_COUNT   = 4
) (
  input  logic clk,
  input  logic rst,
  taxi_axi_xbar_thread_ctrl_if.slave bus
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam int CNT_W = $clog2(S_ACCEPT + 1);
  localparam int IDX_W = (S_THREADS > 1) ? $clog2(S_THREADS) : 1;
  localparam logic [CNT_W-1:0] ACC_MAX = CNT_W'(S_ACCEPT);

  logic [S_THREADS-1:0] vld_q, vld_d;
  logic [ID_W-1:0]      id_q  [S_THREADS];
  logic [ID_W-1:0]      id_d  [S_THREADS];
  logic [SEL_W-1:0]     sel_q [S_THREADS];
  logic [SEL_W-1:0]     sel_d [S_THREADS];
  logic [CNT_W-1:0]     cnt_q [S_THREADS];
  logic [CNT_W-1:0]     cnt_d [S_THREADS];
  logic [CNT_W-1:0]     active_q, active_d;

  logic             id_hit, free_found, cpl_hit;
  logic [IDX_W-1:0] hit_idx, free_idx, cpl_idx, acc_idx;
  logic             ready, accept, alloc, cpl_do;

  // Table lookup for the request ID, the lowest free entry and the completing ID.
  always_comb begin
    id_hit     = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    cpl_hit    = 1'b0;
    cpl_idx    = '0;
    for (int i = 0; i < S_THREADS; i++) begin
      if (vld_q[i] && id_q[i] == bus.req_id) begin
        id_hit  = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!vld_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (vld_q[i] && id_q[i] == bus.cpl_id) begin
        cpl_hit = 1'b1;
        cpl_idx = IDX_W'(i);
      end
    end
  end

  // Admission decision. An ID bound to another master port stalls until its entry drains.
  always_comb begin
    ready = 1'b0;
    if (active_q < ACC_MAX) begin
      if (id_hit)
        ready = (sel_q[hit_idx] == bus.req_sel) && (cnt_q[hit_idx] < ACC_MAX);
      else
        ready = free_found;
    end
    accept  = bus.req_valid && ready;
    alloc   = accept && !id_hit;
    acc_idx = id_hit ? hit_idx : free_idx;
    cpl_do  = bus.cpl_valid && cpl_hit;
  end

  // Next table state. An accept and a completion on the same entry cancel out.
  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    for (int i = 0; i < S_THREADS; i++) begin
      if (accept && acc_idx == IDX_W'(i) && !(cpl_do && cpl_idx == IDX_W'(i))) begin
        if (alloc) begin
          vld_d[i] = 1'b1;
          id_d[i]  = bus.req_id;
          sel_d[i] = bus.req_sel;
          cnt_d[i] = CNT_W'(1);
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (cpl_do && cpl_idx == IDX_W'(i) && !(accept && acc_idx == IDX_W'(i))) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
        if (cnt_q[i] == CNT_W'(1))
          vld_d[i] = 1'b0;
      end
    end
    if (accept && !cpl_do)
      active_d = active_q + CNT_W'(1);
    else if (cpl_do && !accept)
      active_d = active_q - CNT_W'(1);
  end

  // State registers. Reset discards all in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      active_q <= '0;
      for (int i = 0; i < S_THREADS; i++) begin
        id_q[i]  <= '0;
        sel_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      id_q     <= id_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.active_count = active_q;
  assign bus.busy         = (active_q != '0);

`ifdef TAXI_AXI_XBAR_THREAD_ERR_EN
  logic err_q;
  logic err_cond;

  assign err_cond = bus.cpl_valid && (!cpl_hit || active_q == '0);

  // Sticky flag for completions that match no tracked transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (err_cond)
      err_q <= 1'b1;
  end

  // Flag an unmatched completion during simulation.
  always @(posedge clk) begin
    if (!rst)
      assert (!err_cond) else $error("completion id %0h matches no active thread", bus.cpl_id);
  end

  assign bus.cpl_err = err_q;
`endif

endmodule

// File: tb/tb_taxi_axi_xbar_thread_ctrl.sv
// Directed bench for taxi_axi_xbar_thread_ctrl with default parameters
// (S_THREADS=2, S_ACCEPT=16, ID_W=8, M_COUNT=4).
module tb_taxi_axi_xbar_thread_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  taxi_axi_xbar_thread_ctrl_if #(.ID_W(8), .SEL_W(2), .CNT_W(5)) bus ();

  taxi_axi_xbar_thread_ctrl #(
    .S_THREADS(2), .S_ACCEPT(16), .ID_W(8), .M_COUNT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rid;
    logic [1:0] rsel;
    logic       rv;
    logic [7:0] cid;
    logic       cv;
    logic       exp_rdy;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [27];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then sample on the falling edge.
  task automatic step(input logic [7:0] rid, input logic [1:0] rsel, input logic rv,
                      input logic [7:0] cid, input logic cv);
    @(posedge clk);
    #1;
    bus.req_id    = rid;
    bus.req_sel   = rsel;
    bus.req_valid = rv;
    bus.cpl_id    = cid;
    bus.cpl_valid = cv;
    @(negedge clk);
  endtask

  initial begin
    // rid rsel rv cid cv | ready count (sampled before the edge)
    vecs[0]  = '{8'd0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 0};
    vecs[1]  = '{8'd5, 2'd1, 1'b1, 8'd0, 1'b0, 1'b1, 0};
    vecs[2]  = '{8'd5, 2'd1, 1'b1, 8'd0, 1'b0, 1'b1, 1};
    vecs[3]  = '{8'd5, 2'd1, 1'b1, 8'd0, 1'b0, 1'b1, 2};
    vecs[4]  = '{8'd5, 2'd2, 1'b1, 8'd0, 1'b0, 1'b0, 3};
    vecs[5]  = '{8'd5, 2'd2, 1'b1, 8'd5, 1'b1, 1'b0, 3};
    vecs[6]  = '{8'd5, 2'd2, 1'b1, 8'd5, 1'b1, 1'b0, 2};
    vecs[7]  = '{8'd5, 2'd2, 1'b1, 8'd5, 1'b1, 1'b0, 1};
    vecs[8]  = '{8'd5, 2'd2, 1'b1, 8'd0, 1'b0, 1'b1, 0};
    vecs[9]  = '{8'd5, 2'd2, 1'b0, 8'd5, 1'b1, 1'b1, 1};
    vecs[10] = '{8'd1, 2'd0, 1'b1, 8'd0, 1'b0, 1'b1, 0};
    vecs[11] = '{8'd2, 2'd3, 1'b1, 8'd0, 1'b0, 1'b1, 1};
    vecs[12] = '{8'd3, 2'd0, 1'b1, 8'd0, 1'b0, 1'b0, 2};
    vecs[13] = '{8'd3, 2'd0, 1'b1, 8'd1, 1'b1, 1'b0, 2};
    vecs[14] = '{8'd3, 2'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1};
    vecs[15] = '{8'd9, 2'd0, 1'b0, 8'd2, 1'b1, 1'b0, 2};
    vecs[16] = '{8'd2, 2'd1, 1'b0, 8'd3, 1'b1, 1'b1, 1};
    vecs[17] = '{8'd0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 0};
    vecs[18] = '{8'd4, 2'd1, 1'b1, 8'd0, 1'b0, 1'b1, 0};
    vecs[19] = '{8'd4, 2'd1, 1'b1, 8'd4, 1'b1, 1'b1, 1};
    vecs[20] = '{8'd4, 2'd2, 1'b0, 8'd0, 1'b0, 1'b0, 1};
    vecs[21] = '{8'd4, 2'd2, 1'b0, 8'd4, 1'b1, 1'b0, 1};
    vecs[22] = '{8'd4, 2'd2, 1'b1, 8'd0, 1'b0, 1'b1, 0};
    vecs[23] = '{8'd6, 2'd0, 1'b1, 8'd4, 1'b1, 1'b1, 1};
    vecs[24] = '{8'd6, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1};
    vecs[25] = '{8'd6, 2'd0, 1'b0, 8'd6, 1'b1, 1'b1, 1};
    vecs[26] = '{8'd0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1, 0};

    bus.req_id    = '0;
    bus.req_sel   = '0;
    bus.req_valid = 1'b0;
    bus.cpl_id    = '0;
    bus.cpl_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_count", int'(bus.active_count), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_ready", int'(bus.req_ready), 1);
`ifdef TAXI_AXI_XBAR_THREAD_ERR_EN
    chk("reset_err", int'(bus.cpl_err), 0);
`endif
    rst = 1'b0;

    for (int v = 0; v < 27; v++) begin
      step(vecs[v].rid, vecs[v].rsel, vecs[v].rv, vecs[v].cid, vecs[v].cv);
      chk($sformatf("vec%0d_ready", v), int'(bus.req_ready), int'(vecs[v].exp_rdy));
      chk($sformatf("vec%0d_count", v), int'(bus.active_count), vecs[v].exp_cnt);
      chk($sformatf("vec%0d_busy", v), int'(bus.busy), (vecs[v].exp_cnt != 0) ? 1 : 0);
    end

    // Global limit: 16 accepts on id 7 fill both the thread and the global count.
    for (int k = 0; k < 16; k++) begin
      step(8'd7, 2'd0, 1'b1, 8'd0, 1'b0);
      chk($sformatf("fill%0d_ready", k), int'(bus.req_ready), 1);
      chk($sformatf("fill%0d_count", k), int'(bus.active_count), k);
    end
    step(8'd7, 2'd0, 1'b1, 8'd0, 1'b0);
    chk("full_ready_hit", int'(bus.req_ready), 0);
    chk("full_count", int'(bus.active_count), 16);
    step(8'd8, 2'd1, 1'b1, 8'd0, 1'b0);
    chk("full_ready_alloc", int'(bus.req_ready), 0);
    step(8'd7, 2'd0, 1'b1, 8'd7, 1'b1);
    chk("full_req_cpl_ready", int'(bus.req_ready), 0);
    chk("full_req_cpl_count", int'(bus.active_count), 16);
    step(8'd7, 2'd0, 1'b1, 8'd0, 1'b0);
    chk("refill_ready", int'(bus.req_ready), 1);
    chk("refill_count", int'(bus.active_count), 15);
    step(8'd7, 2'd0, 1'b0, 8'd0, 1'b0);
    chk("refull_count", int'(bus.active_count), 16);
    chk("refull_ready", int'(bus.req_ready), 0);
    for (int k = 0; k < 16; k++)
      step(8'd7, 2'd0, 1'b0, 8'd7, 1'b1);
    step(8'd3, 2'd3, 1'b0, 8'd0, 1'b0);
    chk("drain_count", int'(bus.active_count), 0);
    chk("drain_busy", int'(bus.busy), 0);
    chk("drain_ready", int'(bus.req_ready), 1);

    // Completion with no matching entry leaves the table untouched.
    step(8'd0, 2'd0, 1'b0, 8'd9, 1'b1);
    chk("orphan_cpl_count_pre", int'(bus.active_count), 0);
    step(8'd5, 2'd1, 1'b1, 8'd0, 1'b0);
    chk("orphan_cpl_count", int'(bus.active_count), 0);
    chk("orphan_cpl_ready", int'(bus.req_ready), 1);
`ifdef TAXI_AXI_XBAR_THREAD_ERR_EN
    chk("orphan_cpl_err", int'(bus.cpl_err), 1);
`endif
    step(8'd5, 2'd1, 1'b1, 8'd0, 1'b0);
    step(8'd5, 2'd2, 1'b0, 8'd0, 1'b0);
    chk("pre_rst_count", int'(bus.active_count), 2);
    chk("pre_rst_ready", int'(bus.req_ready), 0);
`ifdef TAXI_AXI_XBAR_THREAD_ERR_EN
    chk("err_sticky", int'(bus.cpl_err), 1);
`endif

    // Asynchronous reset away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", int'(bus.active_count), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_ready", int'(bus.req_ready), 1);
`ifdef TAXI_AXI_XBAR_THREAD_ERR_EN
    chk("async_rst_err", int'(bus.cpl_err), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    step(8'd5, 2'd2, 1'b1, 8'd0, 1'b0);
    chk("post_rst_ready", int'(bus.req_ready), 1);
    step(8'd0, 2'd0, 1'b0, 8'd0, 1'b0);
    chk("post_rst_count", int'(bus.active_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_axi_xbar_thread_ctrl.md
Name: taxi_axi_xbar_thread_ctrl

Overview:
- Per-direction transaction admission controller for a one-slave-port AXI crossbar; one instance serves the write path and one serves the read path.
- Tracks up to S_THREADS active IDs, each bound to one master port, plus a global outstanding count capped at S_ACCEPT.
- Admits a new address-phase request only when issuing it cannot reorder same-ID responses across master ports.
- Retires transactions on completion (B beat, or R beat with RLAST).

Parameters:
- S_THREADS, 2, number of thread table entries (distinct IDs in flight), >=1
- S_ACCEPT, 16, max total outstanding transactions, also the per-thread count limit, >=1
- ID_W, 8, AXI ID width
- M_COUNT, 4, number of master ports
- SEL_W, (M_COUNT>1 ? $clog2(M_COUNT) : 1), derived, master select width
- CNT_W, $clog2(S_ACCEPT+1), derived, counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_id  in  ID_W  ID of the address-phase request
- req_sel  in  SEL_W  decoded target master port
- req_valid  in  1  request present
- req_ready  out  1  request admitted this cycle when req_valid is high
- cpl_id  in  ID_W  ID of the completing transaction
- cpl_valid  in  1  one transaction completes this cycle
- active_count  out  CNT_W  total outstanding transactions
- busy  out  1  active_count != 0
- cpl_err  out  1  sticky error flag; only present when TAXI_AXI_XBAR_THREAD_ERR_EN is defined

Behaviour:
- Thread table state: S_THREADS entries, each holding {vld, id, sel, cnt[CNT_W]}. All state is registered.
- Reset: all vld=0, all cnt=0, active_count=0, busy=0, cpl_err=0. Reset takes effect asynchronously at any time, including mid-burst; in-flight tracking is discarded.
- req_ready is combinational from registered state and req_id/req_sel. It does not depend on req_valid. It is high iff active_count < S_ACCEPT and one of:
  - (a) a vld entry has id==req_id, sel==req_sel and cnt<S_ACCEPT (hit);
  - (b) no vld entry has id==req_id and at least one entry is free (allocate).
- Stall conditions:
  - A vld entry with id==req_id but sel!=req_sel: req_ready=0 (ordering hazard) until that entry frees.
  - Table full with no id match: req_ready=0.
- Accept (req_valid && req_ready):
  - On a hit, that entry's cnt increments.
  - On allocate, the lowest-index free entry gets vld=1, id=req_id, sel=req_sel, cnt=1.
  - active_count increments.
- Completion (cpl_valid): the vld entry with id==cpl_id has cnt decremented. When cnt goes 1->0 the entry sets vld=0. active_count decrements.
- Completion with no matching vld entry: no state change to the table or active_count. cpl_err is set if the feature is compiled in.
- Accept and completion in the same cycle:
  - On the same entry, cnt is unchanged and vld stays 1, even when the pre-cycle cnt was 1.
  - On different entries, each is updated independently and active_count is unchanged.
- An entry freed by a completion is not visible to allocation until the next cycle, because req_ready uses registered state.
- Latency: an accept or completion is reflected in active_count, busy and the table one cycle later.
- IDs are unique across vld entries by construction; at most one entry matches any ID.
- Width rules:
  - cnt never exceeds S_ACCEPT and never underflows; completions at cnt=0 cannot occur, since a matching entry is always vld with cnt>=1.
  - active_count never exceeds S_ACCEPT.

Optional Feature:
- Macro: TAXI_AXI_XBAR_THREAD_ERR_EN
- Defined:
  - cpl_err port exists.
  - cpl_err sets on a cpl_valid with no matching vld entry, or on cpl_valid when active_count==0.
  - cpl_err stays set until rst.
  - Simulation assertion fires on the same condition.
- Undefined:
  - No cpl_err port and no error logic.
  - Unmatched completions are silently ignored.

Test Plan:
- Reset, then idle -> req_ready=1 for any ID/sel; active_count=0; busy=0; all entries free.
- Issue id=5 sel=1 three times, then id=5 sel=2 -> first three accepted, active_count=3. The sel=2 request stalls until three cpl id=5 arrive; it is accepted the cycle after active_count reaches 0.
- S_THREADS=2: accept id=1 sel=0 and id=2 sel=3, then request id=3 -> stalls. After cpl id=1 (cnt 1->0), id=3 is accepted next cycle into entry 0.
- S_ACCEPT=16: 16 accepts with id=7 sel=0 -> 17th stalls with active_count=16. Simultaneous req id=7 sel=0 and cpl id=7 at the limit -> req_ready=0 that cycle; accepted next cycle with count back to 16.
- cnt=1 for id=4, then same-cycle accept id=4 sel match plus cpl id=4 -> entry stays vld, cnt=1, active_count unchanged.
- ERR_EN defined: cpl id=9 with no entry -> cpl_err=1 next cycle, table unchanged; cpl_err stays 1 until rst is asserted mid-traffic, which clears everything asynchronously.
